// File: rtl/bi_mem_tp_wm_clr.sv
//==============================================================================
// Module   : bi_mem_tp_wm_clr
// Brief    : 1R/1W write-masked memory with write-first forwarding, zero reads
//            for out-of-range addresses and a sequential hardware clear engine.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bi_mem_tp_wm_clr #(
    parameter int               WIDTH          = 32,
    parameter int               HEIGHT         = 64,
    parameter int               MASK           = 4,
    parameter int               READ_LATENCY   = 1,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    output logic                       ready_o,
    input  logic                       readEnable_i,
    input  logic [$clog2(HEIGHT)-1:0]  readAddr_i,
    output logic                       readValid_o,
    output logic [WIDTH-1:0]           readData_o,
    input  logic                       writeEnable_i,
    input  logic [MASK-1:0]            writeMask_i,
    input  logic [$clog2(HEIGHT)-1:0]  writeAddr_i,
    input  logic [WIDTH-1:0]           writeData_i
);

    localparam int                c_AW     = $clog2(HEIGHT);
    localparam int                c_CHUNK  = (WIDTH + MASK - 1) / MASK;
    localparam int                c_REST   = WIDTH - (MASK - 1) * c_CHUNK;
    localparam logic [c_AW:0]     c_HEIGHT = (c_AW + 1)'(HEIGHT);
    localparam logic [c_AW-1:0]   c_LAST   = c_AW'(HEIGHT - 1);

    generate
        if (c_REST <= 0) begin : g_bad_rest
            $error("bi_mem_tp_wm_clr: MASK leaves no bits for the last chunk");
        end
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("bi_mem_tp_wm_clr: READ_LATENCY must be 1 or 2");
        end
        if (HEIGHT < 2) begin : g_bad_height
            $error("bi_mem_tp_wm_clr: HEIGHT must be at least 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t c_RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    logic [WIDTH-1:0] r_mem [HEIGHT];
    state_t           r_state;
    logic             r_ready;
    logic [c_AW-1:0]  r_cnt;

    logic [WIDTH-1:0] w_bitmask;
    logic [WIDTH-1:0] w_rd_old;
    logic [WIDTH-1:0] w_rd_word;
    logic             w_rd_in;
    logic             w_wr_in;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_fwd;

    logic             r_v1;
    logic [WIDTH-1:0] r_d1;

    // Expand the per-chunk mask to a per-bit mask; the last chunk absorbs REST bits.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bitmask
            assign w_bitmask[i] = writeMask_i[i / c_CHUNK];
        end
    endgenerate

    assign w_rd_in  = ({1'b0, readAddr_i}  < c_HEIGHT);
    assign w_wr_in  = ({1'b0, writeAddr_i} < c_HEIGHT);
    assign w_rd_acc = r_ready & readEnable_i;
    assign w_wr_acc = rst_i & r_ready & writeEnable_i & w_wr_in;
    assign w_fwd    = w_wr_acc & (writeAddr_i == readAddr_i);

    assign w_rd_old  = w_rd_in ? r_mem[readAddr_i] : '0;
    assign w_rd_word = w_fwd ? ((w_rd_old & ~w_bitmask) | (writeData_i & w_bitmask))
                             : w_rd_old;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= c_RST_STATE;
            r_ready <= ~CLEAR_ON_RESET;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_cnt == c_LAST) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clear_i) begin
                        r_state <= ST_CLEAR;
                        r_ready <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ready <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; the clear engine provides the known state.
    always_ff @(posedge clk_i) begin
        if (rst_i && r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= CLEAR_VALUE;
        end else if (w_wr_acc) begin
            r_mem[writeAddr_i] <= (r_mem[writeAddr_i] & ~w_bitmask)
                                | (writeData_i & w_bitmask);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_d1 <= w_rd_word;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic             r_v2;
            logic [WIDTH-1:0] r_d2;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= r_d1;
                    end
                end
            end

            assign readValid_o = r_v2;
            assign readData_o  = r_d2;
        end else begin : g_lat1
            assign readValid_o = r_v1;
            assign readData_o  = r_d1;
        end
    endgenerate

    assign ready_o = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_bi_mem_tp_wm_clr.sv
//==============================================================================
// Module   : tb_bi_mem_tp_wm_clr
// Brief    : Scoreboard bench: a 32x64 latency-1 instance and a 10x5 latency-2
//            instance with a non-zero clear value, driven by directed vectors.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bi_mem_tp_wm_clr;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   total = 0;
    int   bad   = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    // Instance A: 32-bit x 64, latency 1, clears to zero
    logic        rst_a, a_clear, a_ready, a_re, a_rv, a_we;
    logic [5:0]  a_ra, a_wa;
    logic [31:0] a_rd, a_wd;
    logic [3:0]  a_wm;

    // Instance B: 10-bit x 5, latency 2, clears to 0x0A5
    logic        rst_b, b_clear, b_ready, b_re, b_rv, b_we;
    logic [2:0]  b_ra, b_wa;
    logic [9:0]  b_rd, b_wd;
    logic [3:0]  b_wm;

    bi_mem_tp_wm_clr #(
        .WIDTH(32), .HEIGHT(64), .MASK(4), .READ_LATENCY(1),
        .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'h0)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .clear_i(a_clear), .ready_o(a_ready),
        .readEnable_i(a_re), .readAddr_i(a_ra), .readValid_o(a_rv), .readData_o(a_rd),
        .writeEnable_i(a_we), .writeMask_i(a_wm), .writeAddr_i(a_wa), .writeData_i(a_wd)
    );

    bi_mem_tp_wm_clr #(
        .WIDTH(10), .HEIGHT(5), .MASK(4), .READ_LATENCY(2),
        .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(10'h0A5)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .clear_i(b_clear), .ready_o(b_ready),
        .readEnable_i(b_re), .readAddr_i(b_ra), .readValid_o(b_rv), .readData_o(b_rd),
        .writeEnable_i(b_we), .writeMask_i(b_wm), .writeAddr_i(b_wa), .writeData_i(b_wd)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitors: pop an expectation for every valid pulse, check data and arrival cycle
    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].due < cyc) begin
            chk("a_missing_valid", 32'(cyc), 32'(qa[0].due));
            void'(qa.pop_front());
        end
        if (a_rv) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_valid", 32'(a_rv), 32'h0);
            end else begin
                ea = qa.pop_front();
                chk("a_rdata", a_rd, ea.data);
                chk("a_rlatency", 32'(cyc), 32'(ea.due));
            end
        end
    end

    always @(negedge clk) begin
        while (qb.size() > 0 && qb[0].due < cyc) begin
            chk("b_missing_valid", 32'(cyc), 32'(qb[0].due));
            void'(qb.pop_front());
        end
        if (b_rv) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_valid", 32'(b_rv), 32'h0);
            end else begin
                eb = qb.pop_front();
                chk("b_rdata", 32'(b_rd), eb.data);
                chk("b_rlatency", 32'(cyc), 32'(eb.due));
            end
        end
    end

    task automatic a_drive(input logic re, input logic [5:0] ra, input logic we,
                           input logic [3:0] wm, input logic [5:0] wa,
                           input logic [31:0] wd, input logic [31:0] exp, input bit push);
        exp_t e;
        a_re = re; a_ra = ra; a_we = we; a_wm = wm; a_wa = wa; a_wd = wd;
        if (re && push) begin
            e.data = exp;
            e.due  = cyc + 1;
            qa.push_back(e);
        end
        @(negedge clk);
        a_re = 1'b0; a_we = 1'b0;
    endtask

    task automatic a_rdx(input logic [5:0] ra, input logic [31:0] exp);
        a_drive(1'b1, ra, 1'b0, 4'h0, 6'd0, 32'h0, exp, 1'b1);
    endtask

    task automatic a_wrx(input logic [5:0] wa, input logic [31:0] wd, input logic [3:0] wm);
        a_drive(1'b0, 6'd0, 1'b1, wm, wa, wd, 32'h0, 1'b0);
    endtask

    task automatic b_drive(input logic re, input logic [2:0] ra, input logic we,
                           input logic [3:0] wm, input logic [2:0] wa,
                           input logic [9:0] wd, input logic [9:0] exp, input bit push);
        exp_t e;
        b_re = re; b_ra = ra; b_we = we; b_wm = wm; b_wa = wa; b_wd = wd;
        if (re && push) begin
            e.data = 32'(exp);
            e.due  = cyc + 2;
            qb.push_back(e);
        end
        @(negedge clk);
        b_re = 1'b0; b_we = 1'b0;
    endtask

    task automatic b_rdx(input logic [2:0] ra, input logic [9:0] exp);
        b_drive(1'b1, ra, 1'b0, 4'h0, 3'd0, 10'h0, exp, 1'b1);
    endtask

    task automatic b_wrx(input logic [2:0] wa, input logic [9:0] wd, input logic [3:0] wm);
        b_drive(1'b0, 3'd0, 1'b1, wm, wa, wd, 10'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_a = 1'b0; a_clear = 1'b0; a_re = 1'b0; a_we = 1'b0;
        a_ra = '0; a_wa = '0; a_wd = '0; a_wm = '0;
        rst_b = 1'b0; b_clear = 1'b0; b_re = 1'b0; b_we = 1'b0;
        b_ra = '0; b_wa = '0; b_wd = '0; b_wm = '0;
        repeat (3) @(negedge clk);

        chk("a_reset_ready", 32'(a_ready), 32'h0);
        chk("a_reset_valid", 32'(a_rv), 32'h0);
        chk("a_reset_data", a_rd, 32'h0);
        chk("b_reset_ready", 32'(b_ready), 32'h0);
        chk("b_reset_valid", 32'(b_rv), 32'h0);

        // ---------------- instance A ----------------
        rst_a = 1'b1;
        n = 0;
        while (!a_ready && n < 200) begin n++; @(negedge clk); end
        chk("a_clear_cycles", 32'(n), 32'd64);

        a_rdx(6'd0, 32'h0);
        a_rdx(6'd31, 32'h0);
        a_rdx(6'd63, 32'h0);

        a_wrx(6'd5, 32'hAABBCCDD, 4'b1111);
        a_wrx(6'd5, 32'h11223344, 4'b0101);
        a_rdx(6'd5, 32'hAA22CC44);

        a_wrx(6'd7, 32'h12345678, 4'b1111);
        a_drive(1'b1, 6'd7, 1'b1, 4'b0011, 6'd7, 32'hFFFFFFFF, 32'h1234FFFF, 1'b1);
        a_rdx(6'd7, 32'h1234FFFF);

        a_wrx(6'd5, 32'h00000000, 4'b0000);
        a_rdx(6'd5, 32'hAA22CC44);
        a_drive(1'b1, 6'd5, 1'b1, 4'b1111, 6'd6, 32'h55555555, 32'hAA22CC44, 1'b1);
        a_rdx(6'd6, 32'h55555555);

        // Clear request with same-cycle read (must complete) and write
        a_wrx(6'd10, 32'hCAFEF00D, 4'b1111);
        a_clear = 1'b1;
        a_drive(1'b1, 6'd10, 1'b1, 4'b1111, 6'd11, 32'h01020304, 32'hCAFEF00D, 1'b1);
        a_clear = 1'b0;
        chk("a_ready_drop", 32'(a_ready), 32'h0);

        for (int i = 0; i < 9; i++) begin
            a_clear = 1'b1;
            a_drive(1'b1, 6'(i), 1'b1, 4'b1111, 6'(i), 32'hFFFFFFFF, 32'h0, 1'b0);
        end
        a_clear = 1'b0;

        rst_a = 1'b0;
        #1;
        chk("a_midclear_reset_ready", 32'(a_ready), 32'h0);
        repeat (2) @(negedge clk);
        chk("a_midclear_reset_valid", 32'(a_rv), 32'h0);

        // Restarted clear; writes and reads to word 0 must be dropped throughout
        a_re = 1'b1; a_ra = 6'd0; a_we = 1'b1; a_wa = 6'd0; a_wm = 4'hF; a_wd = 32'hFFFFFFFF;
        rst_a = 1'b1;
        n = 0;
        while (!a_ready && n < 200) begin n++; @(negedge clk); end
        a_re = 1'b0; a_we = 1'b0;
        chk("a_reclear_cycles", 32'(n), 32'd64);

        for (int i = 0; i < 64; i++) a_rdx(6'(i), 32'h0);

        // ---------------- instance B ----------------
        rst_b = 1'b1;
        n = 0;
        while (!b_ready && n < 50) begin n++; @(negedge clk); end
        chk("b_clear_cycles", 32'(n), 32'd5);

        b_rdx(3'd4, 10'h0A5);
        b_wrx(3'd0, 10'h001, 4'hF);
        b_wrx(3'd1, 10'h002, 4'hF);
        b_wrx(3'd2, 10'h003, 4'hF);
        b_rdx(3'd0, 10'h001);
        b_rdx(3'd1, 10'h002);
        b_rdx(3'd2, 10'h003);

        b_wrx(3'd3, 10'h000, 4'hF);
        b_wrx(3'd3, 10'h3FF, 4'b1000);
        b_rdx(3'd3, 10'h200);
        b_wrx(3'd4, 10'h3FF, 4'b0001);
        b_rdx(3'd4, 10'h0A7);

        b_wrx(3'd6, 10'h3FF, 4'hF);
        b_rdx(3'd6, 10'h000);
        b_rdx(3'd3, 10'h200);
        b_rdx(3'd4, 10'h0A7);

        b_drive(1'b1, 3'd1, 1'b1, 4'b0100, 3'd1, 10'h3FF, 10'h1C2, 1'b1);
        b_wrx(3'd1, 10'h000, 4'hF);
        b_rdx(3'd1, 10'h000);
        repeat (3) @(negedge clk);

        // Read in flight when reset hits must never produce a valid pulse
        b_drive(1'b1, 3'd2, 1'b0, 4'h0, 3'd0, 10'h0, 10'h0, 1'b0);
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("b_reset_inflight_valid", 32'(b_rv), 32'h0);

        b_re = 1'b1; b_ra = 3'd0; b_we = 1'b1; b_wa = 3'd0; b_wm = 4'hF; b_wd = 10'h3FF;
        rst_b = 1'b1;
        n = 0;
        while (!b_ready && n < 50) begin n++; @(negedge clk); end
        b_re = 1'b0; b_we = 1'b0;
        chk("b_reclear_cycles", 32'(n), 32'd5);

        for (int i = 0; i < 5; i++) b_rdx(3'(i), 10'h0A5);

        repeat (5) @(negedge clk);
        chk("a_queue_drained", 32'(qa.size()), 32'h0);
        chk("b_queue_drained", 32'(qb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
